// File: rtl/lsu_sb_pkg.sv
// Shared types for the LSU store buffer: entry layout, drain FSM states and access-size encodings.
package lsu_sb_pkg;

  localparam int SB_ADDR_BITS = 32;
  localparam int SB_DATA_BITS = 64;

  typedef enum logic [2:0] {
    SZ_BYTE  = 3'd0,
    SZ_HALF  = 3'd1,
    SZ_WORD  = 3'd2,
    SZ_DWORD = 3'd3
  } sbSize_e;

  typedef struct packed {
    logic [SB_ADDR_BITS-1:0] addr;
    logic [SB_DATA_BITS-1:0] data;
    logic [2:0]              size;
  } sbEntry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sbState_e;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular FIFO of store entries with per-entry valid bits and dword-address taps for alias probing.
// Head is read combinationally; a push while full or a pop while empty is ignored.
module store_buffer_fifo
  import lsu_sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_push_vld,
  input  sbEntry_t                  i_push_dat,
  input  logic                      i_pop,
  output sbEntry_t                  o_head_dat,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [DEPTH-1:0]          o_entry_vld,
  output logic [SB_ADDR_BITS-4:0]   o_entry_dw [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);

  sbEntry_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_head];
  assign w_push     = i_push_vld & ~o_full;
  assign w_pop      = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_push_dat;
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    o_entry_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_entry_vld[i] = ({1'b0, PTR_W'(i) - r_head} < r_count);
      o_entry_dw[i]  = r_mem[i].addr[SB_ADDR_BITS-1:3];
    end
  end

endmodule

// File: rtl/lsu_store_drain_ctrl.sv
// Drains committed stores to the dcache store port one at a time; push-to-valid is 2 cycles.
// Commit is stalled when full, one entry early on a live commit, and while a flush is pending.
module lsu_store_drain_ctrl
  import lsu_sb_pkg::*;
#(
  parameter int SB_DEPTH  = 4,
  parameter int ADDR_BITS = SB_ADDR_BITS,
  parameter int DATA_BITS = SB_DATA_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      recoverFlag_i,
  input  logic                      commitSt_i,
  input  logic [ADDR_BITS-1:0]      commitStAddr_i,
  input  logic [DATA_BITS-1:0]      commitStData_i,
  input  logic [2:0]                commitStSize_i,
  output logic                      stallStCommit_o,
  output logic [ADDR_BITS-1:0]      dc2memStAddr_o,
  output logic [DATA_BITS-1:0]      dc2memStData_o,
  output logic [2:0]                dc2memStSize_o,
  output logic                      dc2memStValid_o,
  input  logic                      mem2dcStStall_i,
  input  logic                      mem2dcStComplete_i,
  input  logic                      dcFlush_i,
  output logic                      dcFlushDone_o,
  input  logic [ADDR_BITS-1:0]      ldProbeAddr_i,
  output logic                      ldProbeHit_o,
  output logic [$clog2(SB_DEPTH):0] sbCount_o,
  output logic                      sbOverflow_o
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  sbState_e               r_state;
  sbState_e               w_state_nxt;
  sbEntry_t               w_push_dat;
  sbEntry_t               w_head_dat;
  logic [SB_DEPTH-1:0]    w_entry_vld;
  logic [ADDR_BITS-4:0]   w_entry_dw [SB_DEPTH];
  logic [CNT_W-1:0]       w_count;
  logic [CNT_W-1:0]       w_push_cnt;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_issue;
  logic                   w_flush_done;
  logic                   w_probe_hit;
  logic                   w_unused;
  logic                   r_flush_pend;
  logic                   r_overflow;
  logic                   r_st_vld;
  logic [ADDR_BITS-1:0]   r_st_addr;
  logic [DATA_BITS-1:0]   r_st_data;
  logic [2:0]             r_st_size;

  // Recovery never cancels committed stores; probe compares at dword granularity.
  assign w_unused = ^{recoverFlag_i, ldProbeAddr_i[2:0]};

  assign w_push          = commitSt_i & ~w_full;
  assign w_push_dat.addr = commitStAddr_i;
  assign w_push_dat.data = commitStData_i;
  assign w_push_dat.size = commitStSize_i;
  assign w_push_cnt      = w_count + CNT_W'(w_push);

  store_buffer_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push_vld  (w_push),
    .i_push_dat  (w_push_dat),
    .i_pop       (w_pop),
    .o_head_dat  (w_head_dat),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_entry_vld (w_entry_vld),
    .o_entry_dw  (w_entry_dw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Transitions look at the occupancy after this cycle's push/pop, so a push into an
  // empty buffer reaches ISSUE on the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE:  if (w_push_cnt != '0) w_state_nxt = ISSUE;
      ISSUE: if (!mem2dcStStall_i) begin
        w_issue     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT:  if (mem2dcStComplete_i) begin
        w_pop       = 1'b1;
        w_state_nxt = (w_push_cnt != CNT_W'(1)) ? ISSUE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st_vld  <= 1'b0;
      r_st_addr <= '0;
      r_st_data <= '0;
      r_st_size <= '0;
    end else begin
      r_st_vld <= w_issue;
      if (w_issue) begin
        r_st_addr <= w_head_dat.addr;
        r_st_data <= w_head_dat.data;
        r_st_size <= w_head_dat.size;
      end
    end
  end

  assign w_flush_done = r_flush_pend & (r_state == IDLE) & w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_pend <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_flush_done)   r_flush_pend <= 1'b0;
      else if (dcFlush_i) r_flush_pend <= 1'b1;
      r_overflow <= r_overflow | (commitSt_i & w_full);
    end
  end

  always_comb begin
    w_probe_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (w_entry_vld[i] && (w_entry_dw[i] == ldProbeAddr_i[ADDR_BITS-1:3])) w_probe_hit = 1'b1;
    end
  end

  assign stallStCommit_o = w_full | r_flush_pend |
                           ((w_count == CNT_W'(SB_DEPTH-1)) & commitSt_i);
  assign dc2memStAddr_o  = r_st_addr;
  assign dc2memStData_o  = r_st_data;
  assign dc2memStSize_o  = r_st_size;
  assign dc2memStValid_o = r_st_vld;
  assign dcFlushDone_o   = w_flush_done;
  assign ldProbeHit_o    = w_probe_hit;
  assign sbCount_o       = w_count;
  assign sbOverflow_o    = r_overflow;

endmodule

// File: tb/tb_lsu_store_drain_ctrl.sv
// Bench for lsu_store_drain_ctrl: vector table, directed corner sequences, then random traffic
// checked every cycle against a queue-based model of the store buffer.
module tb_lsu_store_drain_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        recover, commit, mem_stall, mem_cmp, flush;
  logic [31:0] c_addr, probe;
  logic [63:0] c_data;
  logic [2:0]  c_size;
  logic        stall_o, st_vld, done, hit, ovf;
  logic [31:0] st_addr;
  logic [63:0] st_data;
  logic [2:0]  st_size, cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int vld_pulses = 0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  lsu_store_drain_ctrl #(.SB_DEPTH(D), .ADDR_BITS(32), .DATA_BITS(64)) dut (
    .clk(clk), .reset(reset), .recoverFlag_i(recover),
    .commitSt_i(commit), .commitStAddr_i(c_addr), .commitStData_i(c_data),
    .commitStSize_i(c_size), .stallStCommit_o(stall_o),
    .dc2memStAddr_o(st_addr), .dc2memStData_o(st_data), .dc2memStSize_o(st_size),
    .dc2memStValid_o(st_vld), .mem2dcStStall_i(mem_stall), .mem2dcStComplete_i(mem_cmp),
    .dcFlush_i(flush), .dcFlushDone_o(done), .ldProbeAddr_i(probe), .ldProbeHit_o(hit),
    .sbCount_o(cnt), .sbOverflow_o(ovf)
  );

  typedef struct { logic [31:0] addr; logic [63:0] data; logic [2:0] size; } ent_t;

  // Model: FIFO contents, whether one store is in flight, flush pending, last issued store.
  ent_t        mq[$];
  bit          m_out, m_pend, m_ovf, m_vld;
  logic [31:0] m_addr;
  logic [63:0] m_data;
  logic [2:0]  m_size;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] p);
    foreach (mq[k]) if (mq[k].addr[31:3] == p[31:3]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out = 0; m_pend = 0; m_ovf = 0; m_vld = 0;
    m_addr = '0; m_data = '0; m_size = '0;
    cyc = 0;
  endtask

  task automatic idle_in();
    recover = 0; commit = 0; mem_stall = 0; mem_cmp = 0; flush = 0;
    c_addr = '0; c_data = '0; c_size = '0;
  endtask

  // Compare the cycle's outputs with the model, then advance the model across the clock edge.
  task automatic tick(input bit do_chk);
    bit   e_stall, e_done, was_full;
    ent_t e;
    #1;
    was_full = (mq.size() == D);
    e_stall  = was_full || m_pend || (mq.size() == D-1 && commit);
    e_done   = m_pend && !m_out && mq.size() == 0;
    if (do_chk) begin
      chk("stall", stall_o, e_stall);
      chk("count", cnt, mq.size());
      chk("valid", st_vld, m_vld);
      chk("st_addr", st_addr, m_addr);
      chk("st_data", st_data, m_data);
      chk("st_size", st_size, m_size);
      chk("probe_hit", hit, m_hit(probe));
      chk("flush_done", done, e_done);
      chk("overflow", ovf, m_ovf);
    end
    if (st_vld) vld_pulses++;
    if (done) done_pulses++;
    if (!m_out && mq.size() > 0 && !mem_stall) begin
      m_vld = 1; m_addr = mq[0].addr; m_data = mq[0].data; m_size = mq[0].size; m_out = 1;
    end else begin
      m_vld = 0;
      if (m_out && mem_cmp) begin
        m_out = 0;
        void'(mq.pop_front());
      end
    end
    if (commit) begin
      if (was_full) m_ovf = 1;
      else begin
        e.addr = c_addr; e.data = c_data; e.size = c_size;
        mq.push_back(e);
      end
    end
    if (e_done) m_pend = 0;
    else if (flush) m_pend = 1;
    @(negedge clk);
    cyc++;
  endtask

  typedef struct {
    bit commit; bit cmp; bit e_vld; logic [31:0] e_addr; logic [63:0] e_data; int e_cnt; bit e_hit;
  } vec_t;

  function automatic vec_t mk(bit cm, bit cp, bit v, logic [31:0] a, int n, bit h);
    vec_t r;
    r.commit = cm; r.cmp = cp; r.e_vld = v; r.e_addr = a;
    r.e_data = (a != 0) ? 64'hAB : 64'h0; r.e_cnt = n; r.e_hit = h;
    return r;
  endfunction

  vec_t        tv[13];
  logic [31:0] seen[$];
  int          first_vld, first_done, second_done;

  initial begin
    // Single store: push at cycle 5, valid at 7, complete at 10, empty at 11.
    // A completion at cycle 3 arrives outside WAIT and must be ignored.
    tv[0]  = mk(0, 0, 0, 32'h0,    0, 0);
    tv[1]  = mk(0, 0, 0, 32'h0,    0, 0);
    tv[2]  = mk(0, 0, 0, 32'h0,    0, 0);
    tv[3]  = mk(0, 1, 0, 32'h0,    0, 0);
    tv[4]  = mk(0, 0, 0, 32'h0,    0, 0);
    tv[5]  = mk(1, 0, 0, 32'h0,    0, 0);
    tv[6]  = mk(0, 0, 0, 32'h0,    1, 1);
    tv[7]  = mk(0, 0, 1, 32'h1000, 1, 1);
    tv[8]  = mk(0, 0, 0, 32'h1000, 1, 1);
    tv[9]  = mk(0, 0, 0, 32'h1000, 1, 1);
    tv[10] = mk(0, 1, 0, 32'h1000, 1, 1);
    tv[11] = mk(0, 0, 0, 32'h1000, 0, 0);
    tv[12] = mk(0, 0, 0, 32'h1000, 0, 0);

    idle_in();
    probe = 32'h1000;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", st_vld, 0);
    chk("reset_addr", st_addr, 0);
    chk("reset_count", cnt, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_stall", stall_o, 0);
    @(negedge clk);
    reset = 0;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      idle_in();
      commit = tv[i].commit; mem_cmp = tv[i].cmp;
      c_addr = 32'h1000; c_data = 64'hAB; c_size = 3'd0; probe = 32'h1000;
      #1;
      chk("tbl_valid", st_vld, tv[i].e_vld);
      chk("tbl_addr", st_addr, tv[i].e_addr);
      chk("tbl_data", st_data, tv[i].e_data);
      chk("tbl_count", cnt, tv[i].e_cnt);
      chk("tbl_hit", hit, tv[i].e_hit);
      chk("tbl_stall", stall_o, 0);
      tick(0);
    end

    // Memory stall during cycles 6..9 delays the single issue to cycle 11.
    vld_pulses = 0; first_vld = -1;
    for (int t = 0; t < 16; t++) begin
      idle_in();
      commit = (t == 5); c_addr = 32'h3000; c_data = 64'h55; c_size = 3'd3;
      mem_stall = (t >= 6 && t <= 9);
      mem_cmp = (t == 13);
      probe = 32'h0;
      if (st_vld === 1'b1 && first_vld < 0) first_vld = t;
      tick(1);
    end
    chk("stall_first_valid", first_vld, 11);
    chk("stall_pulses", vld_pulses, 1);

    // Fill to four, force a fifth push, then drain in order.
    seen.delete();
    for (int t = 0; t < 32; t++) begin
      idle_in();
      commit = (t <= 4);
      c_addr = 32'h4000 + 32'(t) * 32'h40; c_data = 64'(t) + 64'h100; c_size = 3'd2;
      mem_cmp = (t >= 8);
      probe = 32'h4040;
      if (st_vld === 1'b1) seen.push_back(st_addr);
      #1;
      if (t == 3) chk("fill_stall_4th", stall_o, 1);
      if (t == 5) begin
        chk("fill_stall_full", stall_o, 1);
        chk("fill_count", cnt, 4);
        chk("fill_overflow", ovf, 1);
      end
      tick(1);
    end
    chk("drain_n", seen.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < seen.size()) chk("drain_order", seen[k], 32'h4000 + 32'(k) * 32'h40);

    // Flush with two buffered stores, then a flush while empty.
    done_pulses = 0; first_done = -1; second_done = -1;
    for (int t = 0; t < 18; t++) begin
      idle_in();
      commit = (t <= 1); c_addr = 32'h5000 + 32'(t) * 32'h8; c_data = 64'hF0; c_size = 3'd3;
      flush = (t == 3 || t == 5 || t == 14);
      mem_cmp = (t == 6 || t == 10);
      probe = 32'h0;
      #1;
      if (done === 1'b1) begin
        if (first_done < 0) first_done = t;
        else if (second_done < 0) second_done = t;
      end
      if (t == 4) chk("flush_stall", stall_o, 1);
      tick(1);
    end
    chk("flush_done_first", first_done, 11);
    chk("flush_done_empty", second_done, 15);
    chk("flush_done_pulses", done_pulses, 2);

    // Probe: same-cycle push invisible, dword alias hits, neighbouring dword misses.
    for (int t = 0; t < 9; t++) begin
      idle_in();
      commit = (t == 0); c_addr = 32'h2008; c_data = 64'h77; c_size = 3'd1;
      mem_cmp = (t == 6);
      case (t)
        0, 1:    probe = 32'h2008;
        3:       probe = 32'h200C;
        4:       probe = 32'h2010;
        default: probe = 32'h2008;
      endcase
      #1;
      if (t == 0) chk("probe_same_cycle", hit, 0);
      if (t == 3) chk("probe_alias", hit, 1);
      if (t == 4) chk("probe_next_dword", hit, 0);
      if (t == 8) chk("probe_after_pop", hit, 0);
      tick(1);
    end

    // Asynchronous reset while a store is outstanding.
    for (int t = 0; t < 4; t++) begin
      idle_in();
      commit = (t == 0); c_addr = 32'h6000; c_data = 64'h99; c_size = 3'd3;
      probe = 32'h6000;
      tick(1);
    end
    idle_in();
    probe = 32'h6000;
    #3 reset = 1;
    #1;
    chk("arst_valid", st_vld, 0);
    chk("arst_addr", st_addr, 0);
    chk("arst_data", st_data, 0);
    chk("arst_count", cnt, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_hit", hit, 0);
    chk("arst_stall", stall_o, 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    vld_pulses = 0;
    for (int t = 0; t < 8; t++) begin
      idle_in();
      mem_cmp = (t == 2);
      probe = 32'h6000;
      tick(1);
    end
    chk("arst_no_issue", vld_pulses, 0);

    // Random traffic against the model.
    for (int t = 0; t < 1500; t++) begin
      recover   = 1'($urandom % 2);
      commit    = 1'($urandom % 2);
      c_addr    = 32'h8000 | (32'($urandom % 16) << 3) | 32'($urandom % 8);
      c_data    = {$urandom, $urandom};
      c_size    = 3'($urandom % 4);
      mem_stall = ($urandom % 4) == 0;
      mem_cmp   = ($urandom % 3) == 0;
      flush     = ($urandom % 50) == 0;
      probe     = 32'h8000 | (32'($urandom % 16) << 3) | 32'($urandom % 8);
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
